// File: rtl/adc_pulse_emulator_if.sv
// adc_pulse_emulator_if: control and sample bus of the pulse emulator
interface adc_pulse_emulator_if #(
    parameter int SIZE_ADC_DATA = 12
);
    logic                     start;
    logic                     auto_en;
    logic [15:0]              period;
    logic [SIZE_ADC_DATA-1:0] amplitude;
    logic [SIZE_ADC_DATA-1:0] baseline;
    logic [2:0]               rise_shift;
    logic [3:0]               decay_shift;
    logic [SIZE_ADC_DATA-1:0] sample_out;
    logic                     busy;
    logic [15:0]              pulse_count;
    logic [15:0]              missed_count;

    modport master (
        output start, auto_en, period, amplitude, baseline, rise_shift, decay_shift,
        input  sample_out, busy, pulse_count, missed_count
    );

    modport slave (
        input  start, auto_en, period, amplitude, baseline, rise_shift, decay_shift,
        output sample_out, busy, pulse_count, missed_count
    );
endinterface

// File: rtl/adc_pulse_emulator.sv
// adc_pulse_emulator: baseline plus linear-rise / exponential-decay pulses, one sample per clock
module adc_pulse_emulator #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int FRAC          = 8
) (
    input logic                clk,
    input logic                reset,
    adc_pulse_emulator_if.slave bus
);
    localparam int PW = SIZE_ADC_DATA + FRAC;
    localparam int AW = PW + 7;

    typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

    state_t                   state;
    logic [PW-1:0]            p;
    logic [AW-1:0]            acc;
    logic [7:0]               k;
    logic [15:0]              tcnt;
    logic [SIZE_ADC_DATA-1:0] amp_l;
    logic [2:0]               rs_l;
    logic [3:0]               ds_l;

    logic                     tc_hit;
    logic                     trig;
    logic [AW-1:0]            amp_in_f;
    logic [AW-1:0]            acc_next;
    logic [7:0]               k_next;
    logic [3:0]               ds_eff;
    logic [PW-1:0]            p_dec;
    logic [SIZE_ADC_DATA:0]   sum;

    assign tc_hit   = bus.auto_en && bus.period != 16'd0 && tcnt == bus.period - 16'd1;
    assign trig     = bus.start || tc_hit;
    assign amp_in_f = AW'({bus.amplitude, {FRAC{1'b0}}});
    assign acc_next = acc + AW'({amp_l, {FRAC{1'b0}}});
    assign k_next   = k + 8'd1;
    assign ds_eff   = (ds_l == 4'd0) ? 4'd1 : ds_l;
    assign p_dec    = p >> ds_eff;
    assign sum      = {1'b0, bus.baseline} + {1'b0, p[PW-1:FRAC]};
    assign bus.busy = (state != IDLE);

    // auto-trigger timer: free-runs 0..period-1 regardless of pulse activity
    always_ff @(posedge clk) begin
        if (reset || !bus.auto_en || bus.period == 16'd0)
            tcnt <= 16'd0;
        else
            tcnt <= tc_hit ? 16'd0 : tcnt + 16'd1;
    end

    // pulse shaper FSM with trigger accounting; busy triggers are dropped and counted
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            p                <= '0;
            acc              <= '0;
            k                <= '0;
            amp_l            <= '0;
            rs_l             <= '0;
            ds_l             <= '0;
            bus.pulse_count  <= '0;
            bus.missed_count <= '0;
        end else begin
            if (state != IDLE && trig && bus.missed_count != 16'hFFFF)
                bus.missed_count <= bus.missed_count + 16'd1;
            case (state)
                IDLE: begin
                    p <= '0;
                    if (trig) begin
                        amp_l           <= bus.amplitude;
                        rs_l            <= bus.rise_shift;
                        ds_l            <= bus.decay_shift;
                        acc             <= amp_in_f;
                        k               <= 8'd1;
                        p               <= PW'(amp_in_f >> bus.rise_shift);
                        bus.pulse_count <= bus.pulse_count + 16'd1;
                        state           <= (bus.rise_shift == 3'd0) ? DECAY : RISE;
                    end
                end
                RISE: begin
                    acc <= acc_next;
                    k   <= k_next;
                    p   <= PW'(acc_next >> rs_l);
                    if (k_next == (8'd1 << rs_l))
                        state <= DECAY;
                end
                DECAY: begin
                    if (p_dec == '0) begin
                        p     <= '0;
                        state <= IDLE;
                    end else begin
                        p <= p - p_dec;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // output register: baseline plus integer part of the pulse, clamped to full scale
    always_ff @(posedge clk) begin
        if (reset)
            bus.sample_out <= '0;
        else
            bus.sample_out <= sum[SIZE_ADC_DATA] ? '1 : sum[SIZE_ADC_DATA-1:0];
    end
endmodule

// File: tb/tb_adc_pulse_emulator.sv
// tb_adc_pulse_emulator: randomized and directed checks against a waveform-queue reference model
module tb_adc_pulse_emulator;
    logic clk = 1'b0;
    logic reset = 1'b1;

    adc_pulse_emulator_if #(.SIZE_ADC_DATA(12)) bus();

    adc_pulse_emulator #(.SIZE_ADC_DATA(12), .FRAC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned wave[$];
    int unsigned m_p = 0;
    int unsigned m_tcnt = 0;
    int unsigned m_pulse = 0;
    int unsigned m_missed = 0;
    int unsigned m_sample = 0;
    int unsigned m_busy = 0;
    int unsigned max_s = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: on a trigger the whole pulse is laid out as a queue of p values, one per edge
    task automatic model_edge();
        int unsigned a, r, v, d;
        bit trig;
        trig = bus.start || (bus.auto_en && bus.period != 0 && m_tcnt == int'(bus.period) - 1);
        if (reset) begin
            wave.delete();
            m_p = 0; m_tcnt = 0; m_pulse = 0; m_missed = 0; m_sample = 0; m_busy = 0;
            return;
        end
        v = int'(bus.baseline) + (m_p >> 8);
        m_sample = (v > 4095) ? 4095 : v;
        if (!bus.auto_en || bus.period == 0) m_tcnt = 0;
        else m_tcnt = (m_tcnt == int'(bus.period) - 1) ? 0 : m_tcnt + 1;
        if (wave.size() == 0) begin
            if (trig) begin
                a = bus.amplitude;
                r = 1 << bus.rise_shift;
                for (int i = 1; i <= int'(r); i++) wave.push_back((a * 256 * i) >> bus.rise_shift);
                v = a * 256;
                d = (bus.decay_shift == 0) ? 1 : bus.decay_shift;
                while ((v >> d) != 0) begin
                    v = v - (v >> d);
                    wave.push_back(v);
                end
                wave.push_back(0);
                m_pulse = (m_pulse + 1) & 32'hFFFF;
            end
        end else if (trig && m_missed != 32'hFFFF) begin
            m_missed++;
        end
        if (wave.size() != 0) m_p = wave.pop_front();
        else m_p = 0;
        m_busy = (wave.size() != 0) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sample", bus.sample_out, m_sample);
        check("busy", bus.busy, m_busy);
        check("pulse_count", bus.pulse_count, m_pulse);
        check("missed_count", bus.missed_count, m_missed);
        if (bus.sample_out > max_s) max_s = bus.sample_out;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 5000) begin
            step();
            n++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic fire();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned prev, s0;
        int sp[6] = '{350, 600, 850, 1100, 850, 662};
        int n;
        bus.start = 0; bus.auto_en = 0; bus.period = 0;
        bus.amplitude = 0; bus.baseline = 100; bus.rise_shift = 0; bus.decay_shift = 0;

        // reset values
        reset = 1'b1;
        repeat (3) step();
        check("rst_sample", bus.sample_out, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        step();
        check("rel_sample", bus.sample_out, 100);

        // single pulse
        bus.amplitude = 1000; bus.rise_shift = 2; bus.decay_shift = 2;
        fire();
        check("e0_busy", bus.busy, 1);
        foreach (sp[i]) begin
            step();
            check("pulse_seq", bus.sample_out, sp[i]);
        end
        n = 0;
        while (bus.busy && n < 5000) begin
            prev = bus.sample_out;
            step();
            check("monotonic", bus.sample_out <= prev, 1);
            n++;
        end
        check("idle_timeout", bus.busy, 0);
        check("single_count", bus.pulse_count, 1);
        step();
        check("back_to_base", bus.sample_out, 100);

        // saturation
        bus.baseline = 4000; bus.rise_shift = 0; bus.decay_shift = 3;
        fire();
        max_s = 0;
        step();
        check("sat_peak", bus.sample_out, 4095);
        wait_idle();
        check("sat_max", max_s, 4095);

        // parameter latching
        bus.baseline = 100; bus.rise_shift = 3; bus.decay_shift = 2;
        fire();
        step();
        bus.amplitude = 200;
        max_s = 0;
        wait_idle();
        check("latch_peak1", max_s, 1100);
        step();
        fire();
        max_s = 0;
        wait_idle();
        check("latch_peak2", max_s, 300);

        // auto trigger with overrun
        bus.baseline = 50; bus.amplitude = 500; bus.rise_shift = 1; bus.decay_shift = 6;
        bus.period = 20; bus.auto_en = 1;
        repeat (300) step();
        check("overrun", bus.missed_count > 0, 1);
        n = 0;
        while (m_tcnt != 19 && n < 40) begin
            step();
            n++;
        end
        check("tcnt_reach", m_tcnt, 19);
        s0 = bus.pulse_count + bus.missed_count;
        fire();
        check("coincide", bus.pulse_count + bus.missed_count - s0, 1);
        bus.auto_en = 0;
        wait_idle();

        // randomized phase
        for (int c = 0; c < 1500; c++) begin
            bus.start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 20) == 0) bus.amplitude = $urandom_range(0, 4095);
            if ($urandom_range(0, 20) == 0) bus.baseline = $urandom_range(0, 4095);
            if ($urandom_range(0, 20) == 0) bus.rise_shift = $urandom_range(0, 7);
            if ($urandom_range(0, 20) == 0) bus.decay_shift = $urandom_range(0, 5);
            if ($urandom_range(0, 60) == 0) bus.auto_en = ~bus.auto_en;
            if (m_tcnt == 0 && $urandom_range(0, 30) == 0) bus.period = $urandom_range(0, 40);
            step();
        end
        bus.start = 0; bus.auto_en = 0;
        wait_idle();

        // reset mid-pulse
        bus.baseline = 100; bus.amplitude = 1000; bus.rise_shift = 1; bus.decay_shift = 4;
        fire();
        repeat (5) step();
        check("mid_busy", bus.busy, 1);
        reset = 1'b1;
        step();
        check("mid_rst_sample", bus.sample_out, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_pulse", bus.pulse_count, 0);
        check("mid_rst_missed", bus.missed_count, 0);
        reset = 1'b0;
        step();
        check("mid_rel_sample", bus.sample_out, 100);
        repeat (10) step();
        check("mid_no_leftover", bus.sample_out, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_pulse_emulator.md
# adc_pulse_emulator

Synthetic detector-pulse source for the filter chain. It emits one unsigned ADC sample per clock: a programmable baseline plus pulses with a linear rise and an exponential decay. Pulses start on an external strobe or on an internal periodic timer. It sits in place of the ADC front end and drives the shaping filters with known, repeatable waveforms, both in the lab and in simulation.

## Interface
- SIZE_ADC_DATA, 12: sample width in bits; also the width of amplitude and baseline.
- FRAC, 8: fractional bits carried in the internal pulse value.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle trigger request.
- auto_en  in  1  enables the periodic internal trigger.
- period  in  16  auto-trigger period in clocks; 0 disables the auto trigger.
- amplitude  in  SIZE_ADC_DATA  pulse height in LSB; latched when a trigger is accepted.
- baseline  in  SIZE_ADC_DATA  DC offset; used live every cycle.
- rise_shift  in  3  rise length is 2^rise_shift clocks; latched when a trigger is accepted.
- decay_shift  in  4  decay time constant of about 2^decay_shift clocks; 0 is treated as 1; latched when a trigger is accepted.
- sample_out  out  SIZE_ADC_DATA  emulated ADC sample, registered.
- busy  out  1  high while state is not IDLE.
- pulse_count  out  16  accepted triggers; wraps at 16 bits.
- missed_count  out  16  triggers that arrived while busy; saturates at 0xFFFF.

## Operation
- **Trigger:** trig = start OR (auto_en AND period≠0 AND tcnt==period-1).
  - When start and the auto trigger coincide, this counts as one trigger.
- **Auto timer:** tcnt counts 0..period-1 and wraps.
  - It is held at 0 when auto_en=0 or period=0.
  - It keeps running while busy.
- **States:** IDLE, RISE, DECAY. The internal pulse value p is unsigned, SIZE_ADC_DATA+FRAC bits, in units of 2^-FRAC LSB.
- **IDLE:** p=0.
  - On trig, latch amplitude, rise_shift and decay_shift.
  - Load acc = amplitude<<FRAC and k=1. Set p = acc>>rise_shift.
  - Increment pulse_count and go to RISE.
- **RISE:** on each edge, acc += amplitude<<FRAC, k += 1, p = acc>>rise_shift.
  - acc is at least SIZE_ADC_DATA+FRAC+7 bits.
  - The transition to DECAY happens on the edge where k reaches 2^rise_shift; at that point p = amplitude<<FRAC exactly.
  - With rise_shift=0, the first loaded value is already the peak, so the state goes straight from IDLE to DECAY.
- **DECAY:** on each edge, if (p>>ds)==0 then set p=0 and go to IDLE. Otherwise p = p - (p>>ds).
- **Triggers while busy:** a trig while the state is not IDLE is dropped and increments missed_count (saturating). The pulse in progress is unaffected.
- **Output:** sample_out = min(baseline + (p>>FRAC), 2^SIZE_ADC_DATA-1), registered from the current p. It is one cycle behind p.
- **Reset:** aborts any pulse immediately.
  - State=IDLE, p=0, acc=0, k=0, tcnt=0.
  - sample_out=0, busy=0, pulse_count=0, missed_count=0.

## Timing
- Let E0 be the edge that samples trig.
  - After E0: busy=1, and p holds rise step 1.
  - After E0+1: sample_out = baseline + floor(amplitude/2^rs).
- The peak value, baseline+amplitude (saturated), appears after edge E0+2^rs.
- busy falls on the edge that performs the DECAY→IDLE transition. One edge later, sample_out equals baseline.
- A new trig is accepted on the same edge that busy falls? **No.** A trig is accepted only when the state is already IDLE at that edge; a trig on the falling edge of busy counts as missed.
- Latched parameters do not change mid-pulse. A baseline change appears on sample_out after 1 edge.
- Throughput: one sample per clock, with no stalls.

## Test plan
- **Reset values:** reset for 3 cycles with baseline=100.
  - During reset, sample_out=0 and busy=0.
  - On the cycle after reset release, sample_out=100.
- **Single pulse:** amplitude=1000, baseline=100, rise_shift=2, decay_shift=2, one start pulse.
  - sample_out sequence: 350, 600, 850, 1100, 850, 662, then monotonic decay back to 100.
  - busy falls once; pulse_count=1.
- **Saturation:** baseline=4000, amplitude=1000, rise_shift=0.
  - Peak sample_out=4095 and never exceeds it.
  - Decay samples stay at or below 4095.
- **Auto trigger with overrun:** auto_en=1, period=20, amplitude=500, decay_shift=6.
  - Pulses outlast the period, so missed_count increments every 20 clocks while busy.
  - pulse_count increments only on triggers that arrive in IDLE.
  - start asserted on a tcnt==19 cycle gives a single increment.
- **Parameter latching:** change amplitude from 1000 to 200 during RISE.
  - The peak is still baseline+1000.
  - The next pulse peaks at baseline+200.
- **Reset mid-pulse:** assert reset during DECAY.
  - After the reset edge, sample_out=0, busy=0 and counters=0.
  - After release, sample_out=baseline with no leftover pulse.
